// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: sync, tick-sampled debounce, press/release pulses.
// Latency: 2 CLK sync + wait for next tick + (STABLE_CNT-1)*DIV CLK; worst case ~STABLE_CNT*DIV+2.
// No backpressure: outputs are free-running levels and one-cycle pulses.
//
// Ports:
//   CLK     system clock, rising edge
//   RST     synchronous active-high reset
//   SW      raw asynchronous switch inputs, one bit per channel
//   LEVEL   debounced state per channel, 1 = pressed (polarity-normalised)
//   PRESS   one-cycle pulse per accepted press (plus auto-repeats when built in)
//   RELEASE one-cycle pulse per accepted release
//   TICK    one-cycle sample strobe, shared by all channels
//
// Optional build: define AUTO_REPEAT_EN to re-pulse PRESS while a button is held,
// first after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int DIV          = 1250000,
  parameter int STABLE_CNT   = 3,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] SW,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic            TICK
);

  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int STW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;

  localparam logic [CW-1:0]   CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]   CNT_PRE   = CW'(DIV - 2);
  localparam logic [STW-1:0]  STAB_LAST = STW'(STABLE_CNT - 1);
  // Raw value of an unpressed switch; also the synchroniser reset value so
  // that leaving reset never looks like a press.
  localparam logic [N_CH-1:0] IDLE      = (ACTIVE_LOW != 0) ? '1 : '0;

  // ---------------------------------------------------------------------------
  // Tick divider. TICK is registered one count early so it is high exactly
  // while the counter sits at DIV-1.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      TICK  <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      TICK  <= (cnt_q == CNT_PRE);
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, clocked every cycle; XOR with IDLE normalises so
  // that s=1 means pressed regardless of board polarity.
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] sync1_q, sync2_q, s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ IDLE;

  // ---------------------------------------------------------------------------
  // Per-channel stability counters and pulse generation.
  // ---------------------------------------------------------------------------
  logic [STW-1:0]  stab_q [N_CH];
  logic [STW-1:0]  stab_d [N_CH];
  logic [N_CH-1:0] level_d, press_d, release_d;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE);

  // rep counts ticks since acceptance or since the last repeat; first_q
  // selects whether the initial delay or the repeat rate is the target.
  logic [RW-1:0]   rep_q [N_CH];
  logic [RW-1:0]   rep_d [N_CH];
  logic [RW-1:0]   rep_nxt;
  logic [N_CH-1:0] first_q, first_d;
`endif

  always_comb begin
    level_d   = LEVEL;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      stab_d[i] = stab_q[i];
    end
`ifdef AUTO_REPEAT_EN
    rep_nxt = '0;
    first_d = first_q;
    for (int i = 0; i < N_CH; i++) begin
      rep_d[i] = rep_q[i];
    end
`endif

    if (TICK) begin
      for (int i = 0; i < N_CH; i++) begin
        if (s[i] != LEVEL[i]) begin
          if (stab_q[i] == STAB_LAST) begin
            level_d[i]   = ~LEVEL[i];
            stab_d[i]    = '0;
            press_d[i]   = ~LEVEL[i];
            release_d[i] = LEVEL[i];
          end else begin
            stab_d[i] = stab_q[i] + STW'(1);
          end
        end else begin
          // Any sample agreeing with the current level restarts the count.
          stab_d[i] = '0;
        end

`ifdef AUTO_REPEAT_EN
        // A level change this tick (either way) or an idle channel re-arms
        // the repeat timer; an accepted change always beats a repeat pulse.
        if (!LEVEL[i] || (level_d[i] != LEVEL[i])) begin
          rep_d[i]   = '0;
          first_d[i] = 1'b1;
        end else begin
          rep_nxt = rep_q[i] + RW'(1);
          if (rep_nxt == (first_q[i] ? REP_FIRST : REP_NEXT)) begin
            press_d[i] = 1'b1;
            rep_d[i]   = '0;
            first_d[i] = 1'b0;
          end else begin
            rep_d[i] = rep_nxt;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      LEVEL   <= '0;
      PRESS   <= '0;
      RELEASE <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stab_q[i] <= '0;
      end
`ifdef AUTO_REPEAT_EN
      first_q <= '1;
      for (int i = 0; i < N_CH; i++) begin
        rep_q[i] <= '0;
      end
`endif
    end else begin
      LEVEL   <= level_d;
      PRESS   <= press_d;
      RELEASE <= release_d;
      for (int i = 0; i < N_CH; i++) begin
        stab_q[i] <= stab_d[i];
      end
`ifdef AUTO_REPEAT_EN
      first_q <= first_d;
      for (int i = 0; i < N_CH; i++) begin
        rep_q[i] <= rep_d[i];
      end
`endif
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with DIV=4, STABLE_CNT=3, N_CH=4, active-low switches.
// Timing reference: after an edge at which TICK becomes visible, an input change
// made right then produces its pulse 13 edges later (2 sync + 3 ticks of 4 cycles - 1).
module tb_debounce_multi;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] SW;
  logic [3:0] LEVEL, PRESS, RELEASE;
  logic       TICK;

`ifdef AUTO_REPEAT_EN
  localparam int RP = 1;
`else
  localparam int RP = 0;
`endif

  debounce_multi #(
    .N_CH(4), .DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(1),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .CLK(CLK), .RST(RST), .SW(SW),
    .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] lvl;
    logic [3:0] pm;
    logic [3:0] rm;
    int         np;
    int         nr;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      if (TICK) seen = 1'b1;
    end
    check("wait_tick", {31'd0, seen}, 32'd1);
  endtask

  // Apply sw for n cycles and summarise the pulse activity seen.
  task automatic hold(input logic [3:0] sw, input int n,
                      output int np, output logic [3:0] pm,
                      output int nr, output logic [3:0] rm, output int both);
    np = 0; nr = 0; both = 0; pm = '0; rm = '0;
    SW = sw;
    for (int k = 0; k < n; k++) begin
      step();
      if (PRESS != 0)   np++;
      if (RELEASE != 0) nr++;
      if ((PRESS & RELEASE) != 0) both++;
      pm |= PRESS;
      rm |= RELEASE;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int bad, nt, last, first, gap, np, nr, both, tnp, tnr;
    logic [3:0] pm, rm;
    logic exp;

    tbl[0] = '{4'hE, 4'h1, 4'h1, 4'h0, 1, 0};
    tbl[1] = '{4'hF, 4'h0, (RP != 0) ? 4'h1 : 4'h0, 4'h1, RP, 1};
    tbl[2] = '{4'h3, 4'hC, 4'hC, 4'h0, 1, 0};
    tbl[3] = '{4'hF, 4'h0, (RP != 0) ? 4'hC : 4'h0, 4'hC, RP, 1};
    tbl[4] = '{4'h5, 4'hA, 4'hA, 4'h0, 1, 0};
    tbl[5] = '{4'hF, 4'h0, (RP != 0) ? 4'hA : 4'h0, 4'hA, RP, 1};
    tbl[6] = '{4'h8, 4'h7, 4'h7, 4'h0, 1, 0};
    tbl[7] = '{4'hF, 4'h0, (RP != 0) ? 4'h7 : 4'h0, 4'h7, RP, 1};

    // Reset and idle hold
    SW  = 4'hF;
    RST = 1'b1;
    repeat (3) step();
    check("rst_level",   LEVEL,   4'h0);
    check("rst_press",   PRESS,   4'h0);
    check("rst_release", RELEASE, 4'h0);
    check("rst_tick",    TICK,    1'b0);
    RST = 1'b0;

    bad = 0; nt = 0; last = -1; first = -1; gap = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if ((LEVEL | PRESS | RELEASE) != 0) bad++;
      if (TICK) begin
        if (last >= 0 && (k - last) != 4) gap++;
        if (first < 0) first = k;
        last = k;
        nt++;
      end
    end
    check("idle_outputs", bad, 0);
    check("idle_ticks",   nt, 50);
    check("tick_period",  gap, 0);
    check("first_tick",   first, 3);

    // Single press: exact latency and one-cycle pulse
    wait_tick();
    SW = 4'hE;
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (PRESS != 0 || LEVEL != 0) bad++;
    end
    check("press_early", bad, 0);
    step();
    check("press_pulse", PRESS, 4'h1);
    check("press_level", LEVEL, 4'h1);
    step();
    check("press_once",  PRESS, 4'h0);
    check("press_hold",  LEVEL, 4'h1);

    wait_tick();
    SW = 4'hF;
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (RELEASE != 0 || LEVEL != 4'h1) bad++;
    end
    check("rel_early", bad, 0);
    step();
    check("rel_pulse", RELEASE, 4'h1);
    check("rel_level", LEVEL,   4'h0);
    check("rel_nopress", PRESS, 4'h0);
    step();
    check("rel_once",  RELEASE, 4'h0);

    // Bounce on channel 1: low 2 ticks, high 1, low 2, then high
    wait_tick();
    tnp = 0; tnr = 0;
    hold(4'hD, 8, np, pm, nr, rm, both);  tnp += np; tnr += nr;
    hold(4'hF, 4, np, pm, nr, rm, both);  tnp += np; tnr += nr;
    hold(4'hD, 8, np, pm, nr, rm, both);  tnp += np; tnr += nr;
    hold(4'hF, 20, np, pm, nr, rm, both); tnp += np; tnr += nr;
    check("bounce_press",   tnp, 0);
    check("bounce_release", tnr, 0);
    check("bounce_level",   LEVEL, 4'h0);

    // Reset after two agreeing ticks: the count restarts from scratch
    wait_tick();
    SW = 4'hE;
    repeat (9) step();
    RST = 1'b1;
    step();
    check("mrst_level", LEVEL,   4'h0);
    check("mrst_press", PRESS,   4'h0);
    check("mrst_tick",  TICK,    1'b0);
    RST = 1'b0;
    bad = 0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (PRESS != 0 || LEVEL != 0) bad++;
    end
    check("mrst_no_early", bad, 0);
    step();
    check("mrst_press_late", PRESS, 4'h1);
    step();
    check("mrst_press_once", PRESS, 4'h0);
    hold(4'hF, 24, np, pm, nr, rm, both);
    check("mrst_release", nr, 1);

    // Long hold: auto-repeat timing when built in, single pulse otherwise
    wait_tick();
    SW = 4'hE;
    for (int k = 1; k <= 56; k++) begin
      step();
      exp = (k == 13) || ((RP != 0) && (k == 29 || k == 37 || k == 45 || k == 53));
      check($sformatf("hold_press_k%0d", k), PRESS[0], exp);
    end
    check("hold_level", LEVEL, 4'h1);
    SW = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = (RP != 0) && (k == 5);
      check($sformatf("unhold_press_k%0d", k), PRESS[0], exp);
      check($sformatf("unhold_rel_k%0d", k), RELEASE[0], (k == 13));
    end
    check("unhold_level", LEVEL, 4'h0);

    // Table of level patterns, each held long enough to settle
    for (int i = 0; i < 8; i++) begin
      hold(tbl[i].sw, 24, np, pm, nr, rm, both);
      check($sformatf("row%0d_level", i), LEVEL, tbl[i].lvl);
      check($sformatf("row%0d_pmask", i), pm, tbl[i].pm);
      check($sformatf("row%0d_npress", i), np, tbl[i].np);
      check($sformatf("row%0d_rmask", i), rm, tbl[i].rm);
      check($sformatf("row%0d_nrel", i), nr, tbl[i].nr);
      check($sformatf("row%0d_both", i), both, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
